pwm_bank_manager: RTL and testbench
===================================

Name: pwm_bank_manager

Overview:
- Parametrised successor to the single-port peripheral manager: an address-decoded bank of N_CH independent PWM channels.
- Each channel has memory-mapped ON/OFF/CTRL registers with double buffering (glitch-free period updates) and registered readback.
- Sits on the processor data bus beside RAM. It claims addresses whose top 3 bits equal PREFIX; all other addresses are ignored.

Parameters:
N_CH, 4, number of PWM channels (1..16)
CNT_W, 16, width of ON/OFF cycle counts and counters
PREFIX, 3'b001, value of addr[31:29] that selects this block

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address; [31:29] prefix, [7:4] channel, [3:2] register
data_in  input  32  write data
write_enable  input  1  write strobe, one cycle per access
read_enable  input  1  read strobe, one cycle per access
data_out  output  32  read data, valid the cycle after read_enable
read_valid  output  1  high for one cycle when data_out is valid
pwm_out  output  N_CH  channel outputs, registered

Behaviour:
- Reset (rst_n low, async): all ON/OFF/CTRL shadow and active registers = 0; counters = 0; every FSM in IDLE; pwm_out = 0; data_out = 0; read_valid = 0.
- Decode: hit = (addr[31:29]==PREFIX) && (addr[7:4] < N_CH). Register select addr[3:2]: 0=ON, 1=OFF, 2=CTRL, 3=STATUS (read-only). addr[1:0] and addr[28:8] are ignored.
- Writes: on a clock edge with write_enable && hit, the shadow register is updated. ON/OFF take data_in[CNT_W-1:0]. CTRL takes bit0=enable and bit1=polarity. Writes to STATUS or on a miss have no effect.
- Reads:
  - read_enable && hit registers the selected value into data_out and sets read_valid=1 the next cycle.
  - Readback is zero-extended: ON/OFF return the shadow values, CTRL returns {30'b0, pol, en}, STATUS returns {28'b0, state[1:0], out_raw, period_end}.
  - A miss drives data_out=0 with read_valid=1 if the prefix matched and read_valid=0 otherwise.
  - Simultaneous read and write to the same register returns the old value.
- Per-channel FSM (states IDLE, HIGH, LOW):
  - IDLE: raw=0. When enable=1, load the active ON/OFF from shadow and go to HIGH if ON!=0, else to LOW if OFF!=0, else stay in IDLE.
  - HIGH: raw=1 for exactly ON cycles, then LOW, or the period ends immediately if OFF==0.
  - LOW: raw=0 for exactly OFF cycles.
  - Period end (last cycle of a period): period_end pulses, active registers reload from shadow, and the next period starts using the same entry rule as IDLE. Mid-period shadow writes never alter the current period.
  - enable cleared: the FSM goes to IDLE on the next edge and raw=0.
- Output: pwm_out[i] = raw ^ polarity, registered, so there is 1-cycle latency from the FSM state. Polarity takes effect on the cycle after the write; it is not buffered.
- Edge cases:
  - ON=0, OFF>0: constant inactive level.
  - ON>0, OFF=0: constant active level.
  - Both 0 while enabled: stays in IDLE, output at the inactive level.
  - Max count: 2^CNT_W-1 cycles; counters never wrap mid-phase.
- Asserting reset mid-period aborts immediately to the reset state; nothing is retained.

Test Plan:
1. Reset values: rst_n=0 mid-operation → pwm_out=0, data_out=0, read_valid=0 asynchronously. After release, reading ch0 CTRL returns 0.
2. Basic waveform: write ch1 ON=3, OFF=5, CTRL=1 (addr 0x2000_0010/14/18) → pwm_out[1] repeats 3 high / 5 low, period 8. The first rise is 2 cycles after the CTRL write edge.
3. Double buffering: ch0 running ON=4, OFF=4; write ON=1 during HIGH → the current period still has 4 high cycles, and the next period has 1 high and 4 low.
4. Boundaries on ch2:
   - ON=0, OFF=7 → constant 0.
   - ON=7, OFF=0 → constant 1.
   - Both 0 → constant 0 and STATUS state=IDLE.
   - CTRL=3 with ON=0, OFF=7 → constant 1 (polarity inversion).
5. Decode and readback:
   - Write ON=0xABCD to ch0 → read returns 0x0000ABCD with read_valid the next cycle.
   - Access to channel N_CH → data_out=0, with no effect on any channel.
   - Addr prefix 000 → read_valid=0 and no write.
6. Disable mid-period: clear enable during HIGH → pwm_out returns to the inactive level within 2 cycles. Re-enabling starts a fresh period with the current shadow values.

Source files
------------

// File: rtl/pwm_bank_manager.sv
// pwm_bank_manager: address-decoded bank of N_CH double-buffered PWM channels.
//
// Ports:
//   clk, rst_n    - system clock (rising edge), async active-low reset
//   addr          - byte address: [31:29] block prefix, [7:4] channel, [3:2] register
//   data_in       - write data
//   write_enable  - write strobe, one cycle per access
//   read_enable   - read strobe, one cycle per access
//   data_out      - read data, registered (valid the cycle after read_enable)
//   read_valid    - one-cycle pulse qualifying data_out
//   pwm_out       - per-channel PWM outputs, registered
//
// Register map per channel (addr[3:2]): 0=ON, 1=OFF, 2=CTRL {pol,en}, 3=STATUS (RO).

// pwm_channel: one PWM lane. Holds the shadow ON/OFF/CTRL registers, the
// active OFF copy for the running period, and the IDLE/HIGH/LOW sequencer.
//
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   wr_on/wr_off/wr_ctrl - write strobes for the shadow registers
//   wval, wctrl        - count value for ON/OFF, {pol,en} for CTRL
//   sh_on, sh_off      - shadow values for readback
//   en, pol            - control bits
//   state_o, raw, period_end - status fields
//   pwm_out            - registered output (raw ^ pol)
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_on,
    input  logic             wr_off,
    input  logic             wr_ctrl,
    input  logic [CNT_W-1:0] wval,
    input  logic [1:0]       wctrl,
    output logic [CNT_W-1:0] sh_on,
    output logic [CNT_W-1:0] sh_off,
    output logic             en,
    output logic             pol,
    output logic [1:0]       state_o,
    output logic             raw,
    output logic             period_end,
    output logic             pwm_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} st_t;

    st_t              state;
    logic [CNT_W-1:0] cnt;      // cycles left in current phase, counts down to 1
    logic [CNT_W-1:0] act_off;  // OFF length latched at period start
    st_t              ent_state;
    logic [CNT_W-1:0] ent_cnt;

    // Entry rule shared by IDLE and period end: HIGH if ON!=0, else LOW if OFF!=0.
    always_comb begin
        ent_state = IDLE;
        ent_cnt   = '0;
        if (sh_on != '0) begin
            ent_state = HIGH;
            ent_cnt   = sh_on;
        end else if (sh_off != '0) begin
            ent_state = LOW;
            ent_cnt   = sh_off;
        end
    end

    assign raw        = (state == HIGH);
    assign state_o    = state;
    assign period_end = en && (cnt == CNT_W'(1)) &&
                        ((state == LOW) || (state == HIGH && act_off == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_on   <= '0;
            sh_off  <= '0;
            en      <= 1'b0;
            pol     <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            act_off <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (wr_on)   sh_on  <= wval;
            if (wr_off)  sh_off <= wval;
            if (wr_ctrl) {pol, en} <= wctrl;

            pwm_out <= raw ^ pol;

            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ent_state;
                        cnt     <= ent_cnt;
                        act_off <= sh_off;
                    end
                    HIGH: begin
                        if (cnt != CNT_W'(1)) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (act_off == '0) begin
                            state   <= ent_state;
                            cnt     <= ent_cnt;
                            act_off <= sh_off;
                        end else begin
                            state <= LOW;
                            cnt   <= act_off;
                        end
                    end
                    LOW: begin
                        if (cnt != CNT_W'(1)) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            state   <= ent_state;
                            cnt     <= ent_cnt;
                            act_off <= sh_off;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module pwm_bank_manager #(
    parameter int         N_CH   = 4,
    parameter int         CNT_W  = 16,
    parameter logic [2:0] PREFIX = 3'b001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     addr,
    input  logic [31:0]     data_in,
    input  logic            write_enable,
    input  logic            read_enable,
    output logic [31:0]     data_out,
    output logic            read_valid,
    output logic [N_CH-1:0] pwm_out
);
    logic [N_CH-1:0][CNT_W-1:0] sh_on, sh_off;
    logic [N_CH-1:0][1:0]       st;
    logic [N_CH-1:0]            en, pol, raw, pe;

    logic [3:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic        pfx_hit, hit;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign ch_sel  = addr[7:4];
    assign reg_sel = addr[3:2];
    assign pfx_hit = (addr[31:29] == PREFIX);
    assign hit     = pfx_hit && ({1'b0, ch_sel} < 5'(N_CH));
    assign unused_ok = ^{addr[28:8], addr[1:0], data_in};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        assign sel = write_enable && hit && (ch_sel == 4'(i));
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_on      (sel && reg_sel == 2'd0),
            .wr_off     (sel && reg_sel == 2'd1),
            .wr_ctrl    (sel && reg_sel == 2'd2),
            .wval       (data_in[CNT_W-1:0]),
            .wctrl      (data_in[1:0]),
            .sh_on      (sh_on[i]),
            .sh_off     (sh_off[i]),
            .en         (en[i]),
            .pol        (pol[i]),
            .state_o    (st[i]),
            .raw        (raw[i]),
            .period_end (pe[i]),
            .pwm_out    (pwm_out[i])
        );
    end

    // Out-of-range channels match no lane and read back as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 4'(i)) begin
                case (reg_sel)
                    2'd0:    rd_val = 32'(sh_on[i]);
                    2'd1:    rd_val = 32'(sh_off[i]);
                    2'd2:    rd_val = {30'b0, pol[i], en[i]};
                    default: rd_val = {28'b0, st[i], raw[i], pe[i]};
                endcase
            end
        end
    end

    // Registered read port; same-cycle writes land after the sample, so old data is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_enable && pfx_hit;
            if (read_enable) data_out <= pfx_hit ? rd_val : 32'h0;
        end
    end
endmodule

// File: tb/tb_pwm_bank_manager.sv
// Self-checking bench for pwm_bank_manager: read scoreboard plus per-cycle
// waveform checks on pwm_out.
module tb_pwm_bank_manager;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] data_out;
    logic        read_valid;
    logic [3:0]  pwm_out;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sbq[$];

    pwm_bank_manager #(.N_CH(4), .CNT_W(16), .PREFIX(3'b001)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .read_valid   (read_valid),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid read pops the expected word pushed at issue time.
    always @(posedge clk) begin
        #1;
        if (read_valid === 1'b1) begin
            if (sbq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else                 chk("rd_data", data_out, sbq.pop_front());
        end
    end

    function automatic logic [31:0] ra(input int ch, input int r);
        return 32'h2000_0000 | 32'(ch << 4) | 32'(r << 2);
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; data_in = d; write_enable = 1'b1;
        @(posedge clk); #2;
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic ev, input logic [31:0] ed);
        addr = a; read_enable = 1'b1;
        if (ev) sbq.push_back(ed);
        @(posedge clk); #2;
        read_enable = 1'b0;
        chk("rd_valid", 32'(read_valid), 32'(ev));
    endtask

    task automatic wait_high(input int ch);
        int t = 0;
        while (pwm_out[ch] !== 1'b1 && t < 40) begin tick(); t++; end
        chk("wait_high", 32'(pwm_out[ch]), 32'd1);
    endtask

    // Program ch2 from a disabled state and check a constant output level.
    task automatic const_run(input int on, input int off, input int ctrl, input logic lvl);
        wr(ra(2, 2), 0);
        wr(ra(2, 0), 32'(on));
        wr(ra(2, 1), 32'(off));
        wr(ra(2, 2), 32'(ctrl));
        tick(); tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("t4_const", 32'(pwm_out[2]), 32'(lvl));
        end
    endtask

    initial begin
        logic e;
        // Reset state
        #1;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_vld", 32'(read_valid), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        tick();
        rd(ra(0, 2), 1'b1, 32'd0);

        // Basic waveform on ch1: 3 high / 5 low, first rise 2 cycles after enable
        wr(ra(1, 0), 3);
        wr(ra(1, 1), 5);
        wr(ra(1, 2), 1);
        for (int k = 1; k <= 26; k++) begin
            tick();
            e = (k >= 2) && (((k - 2) % 8) < 3);
            chk("t2_wave", 32'(pwm_out[1]), 32'(e));
        end
        chk("t2_ch0_idle", 32'(pwm_out[0]), 32'd0);

        // Double buffering on ch0
        wr(ra(0, 0), 4);
        wr(ra(0, 1), 4);
        wr(ra(0, 2), 1);
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) wr(ra(0, 0), 1);
            else        tick();
            if (k < 10) e = (k >= 2) && (k <= 5);
            else        e = ((k - 10) % 5) == 0;
            chk("t3_wave", 32'(pwm_out[0]), 32'(e));
        end
        wr(ra(0, 2), 0);

        // Boundaries on ch2
        const_run(0, 7, 1, 1'b0);
        const_run(7, 0, 1, 1'b1);
        const_run(0, 0, 1, 1'b0);
        rd(ra(2, 3), 1'b1, 32'd0);
        const_run(0, 7, 3, 1'b1);
        wr(ra(2, 2), 0);

        // Decode and readback
        wr(ra(0, 0), 32'hFFFF_ABCD);
        rd(ra(0, 0), 1'b1, 32'h0000_ABCD);
        rd(ra(0, 2), 1'b1, 32'd0);
        wr(ra(4, 0), 32'h55);
        rd(ra(4, 0), 1'b1, 32'd0);
        rd(ra(0, 0), 1'b1, 32'h0000_ABCD);
        rd(ra(1, 0), 1'b1, 32'd3);
        rd(ra(2, 0), 1'b1, 32'd0);
        rd(ra(3, 0), 1'b1, 32'd0);
        wr(32'h0000_0000, 32'h1234);
        rd(32'h0000_0000, 1'b0, 32'd0);
        rd(32'h2ABC_DE03, 1'b1, 32'h0000_ABCD);
        wr(ra(0, 3), 32'hF);
        rd(ra(0, 2), 1'b1, 32'd0);
        // Read and write the same register in one cycle: old value returned
        addr = ra(0, 1); data_in = 9; write_enable = 1'b1; read_enable = 1'b1;
        sbq.push_back(32'd4);
        @(posedge clk); #2;
        write_enable = 1'b0; read_enable = 1'b0;
        chk("rw_valid", 32'(read_valid), 32'd1);
        rd(ra(0, 1), 1'b1, 32'd9);

        // Disable mid-period on ch1, then re-enable with new shadow values
        wait_high(1);
        wr(ra(1, 2), 0);
        tick(); tick();
        chk("t6_off", 32'(pwm_out[1]), 32'd0);
        rd(ra(1, 3), 1'b1, 32'd0);
        wr(ra(1, 0), 2);
        wr(ra(1, 1), 2);
        wr(ra(1, 2), 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            e = (k >= 2) && (((k - 2) % 4) < 2);
            chk("t6_wave", 32'(pwm_out[1]), 32'(e));
        end

        // Asynchronous reset mid-period
        rd(ra(1, 0), 1'b1, 32'd2);
        wait_high(1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'd0);
        chk("arst_dout", data_out, 32'd0);
        chk("arst_vld", 32'(read_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rd(ra(0, 2), 1'b1, 32'd0);
        rd(ra(1, 0), 1'b1, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("arst_idle", 32'(pwm_out), 32'd0);
        end

        tick();
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
